mtm_alu_deserializer: RTL and testbench

Serial input stage of the mtm_Alu. It samples the `sin` line one bit per clock and assembles 11-bit bytes into 9-byte command frames. It checks each frame's CRC4 and opcode, then presents B, A, op and error flags to the ALU core through a valid/ready register. It sits between the external `sin` pin and the ALU execution stage.

---
 rtl/mtm_Alu_pkg.sv | 43 ++++
 rtl/mtm_alu_crc4.sv | 36 +++
 rtl/mtm_alu_deserializer.sv | 259 +++++++++++++++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_Alu_pkg.sv
// mtm_Alu_pkg: shared types and constants for the mtm_Alu serial front end.
package mtm_Alu_pkg;

    // ALU opcodes as carried in the control byte.
    typedef enum logic [2:0] {
        AND = 3'b000,
        OR  = 3'b001,
        ADD = 3'b100,
        SUB = 3'b101
    } op_t;

    // Type bit that follows every start bit.
    typedef enum logic {
        DATA = 1'b0,
        CTL  = 1'b1
    } byte_type_t;

    // Bit-level receive FSM.
    typedef enum logic [2:0] {
        StIdle,
        StType,
        StPayload,
        StStop,
        StWaitHigh
    } deser_state_e;

    // Error flags; only the highest-priority one is ever reported.
    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    localparam logic [3:0] FRAME_DATA_BYTES = 4'd8;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == AND) || (op == OR) || (op == ADD) || (op == SUB);
    endfunction

    // One serial step of CRC4 with polynomial x^4+x+1, MSB first.
    function automatic logic [3:0] crc4_step(input logic [3:0] r, input logic din);
        return {r[2], r[1], r[3] ^ r[0], r[3] ^ din};
    endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// mtm_alu_crc4: serial CRC4 register (x^4+x+1) with clear, enable and data-in.
module mtm_alu_crc4
    import mtm_Alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [3:0] crc_o
);

    logic [3:0] crc_q, crc_d;

    // Clear wins over a shift so a frame boundary always restarts from zero.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc4_step(crc_q, din_i);
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: samples sin one bit per clock, assembles 11-bit bytes into
// 9-byte command frames, checks CRC4 and opcode, and hands B/A/op/err to the ALU
// through a valid/ready output register.
// Optional feature: define MTM_ALU_DESER_TIMEOUT_EN to abandon partial frames after
// TIMEOUT_CYCLES idle cycles.
module mtm_alu_deserializer
    import mtm_Alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_B,
    output logic [31:0] out_A,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err,
    output logic        overrun
);

    // Receive-side state.
    deser_state_e state_q, state_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    byte_type_t   type_q, type_d;
    logic [7:0]   shift_q, shift_d;
    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [63:0]  data_q, data_d;

    // Completion strobe and its error code, registered one stage before the output.
    logic         frame_done;
    logic [2:0]   frame_err;
    logic         done_q;
    logic [63:0]  pend_data_q;
    logic [2:0]   pend_op_q;
    logic [2:0]   pend_err_q;

    // CRC engine controls.
    logic         crc_clr, crc_en, crc_din;
    logic [3:0]   crc_val;

    // Output register.
    logic         out_valid_q;
    logic [63:0]  out_data_q;
    logic [2:0]   out_op_q;
    logic [2:0]   out_err_q;
    logic         overrun_q;
    logic         load;

    logic         tmo_fire;

    mtm_alu_crc4 u_crc4 (
        .clk   (clk),
        .rst   (rst),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (crc_din),
        .crc_o (crc_val)
    );

`ifdef MTM_ALU_DESER_TIMEOUT_EN
    localparam int unsigned      TmoW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0]  TmoLimit = TmoW'(TIMEOUT_CYCLES);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Count idle cycles only while a frame is partially received.
    always_comb begin
        tmo_d    = '0;
        tmo_fire = 1'b0;
        if (state_q == StIdle && byte_cnt_q != 4'd0) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TmoLimit) begin
                tmo_fire = 1'b1;
                tmo_d    = '0;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign tmo_fire              = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Bit FSM, byte/frame accounting, CRC feed and error classification.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        type_d     = type_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        frame_done = 1'b0;
        frame_err  = 3'b000;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_din    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!sin) begin
                    state_d = StType;
                end
            end
            StType: begin
                type_d    = byte_type_t'(sin);
                bit_idx_d = 3'd0;
                state_d   = StPayload;
            end
            StPayload: begin
                shift_d   = {shift_q[6:0], sin};
                bit_idx_d = bit_idx_q + 3'd1;
                crc_en    = 1'b1;
                if (type_q == CTL) begin
                    // Ctl byte feeds 1, op, then zeros in place of the received CRC.
                    if (bit_idx_q == 3'd0) begin
                        crc_din = 1'b1;
                    end else if (bit_idx_q <= 3'd3) begin
                        crc_din = sin;
                    end else begin
                        crc_din = 1'b0;
                    end
                end else begin
                    crc_din = sin;
                end
                if (bit_idx_q == 3'd7) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                state_d = StIdle;
                if (!sin) begin
                    // Framing error: resync on a high line before the next start bit.
                    frame_done = 1'b1;
                    frame_err  = ERR_DATA;
                    byte_cnt_d = 4'd0;
                    crc_clr    = 1'b1;
                    state_d    = StWaitHigh;
                end else if (type_q == DATA) begin
                    if (byte_cnt_q == FRAME_DATA_BYTES) begin
                        frame_done = 1'b1;
                        frame_err  = ERR_DATA;
                        byte_cnt_d = 4'd0;
                        crc_clr    = 1'b1;
                    end else begin
                        data_d     = {data_q[55:0], shift_q};
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end else begin
                    frame_done = 1'b1;
                    byte_cnt_d = 4'd0;
                    crc_clr    = 1'b1;
                    if (byte_cnt_q != FRAME_DATA_BYTES) begin
                        frame_err = ERR_DATA;
                    end else if (shift_q[3:0] != crc_val) begin
                        frame_err = ERR_CRC;
                    end else if (!op_is_valid(shift_q[6:4])) begin
                        frame_err = ERR_OP;
                    end
                end
            end
            StWaitHigh: begin
                if (sin) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_fire) begin
            frame_done = 1'b1;
            frame_err  = ERR_DATA;
            byte_cnt_d = 4'd0;
            crc_clr    = 1'b1;
        end
    end

    // Receive-side state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_idx_q  <= 3'd0;
            type_q     <= DATA;
            shift_q    <= 8'd0;
            byte_cnt_q <= 4'd0;
            data_q     <= 64'd0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            type_q     <= type_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
        end
    end

    // Capture a completed frame so the output register loads one cycle after the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q      <= 1'b0;
            pend_data_q <= 64'd0;
            pend_op_q   <= 3'd0;
            pend_err_q  <= 3'd0;
        end else begin
            done_q <= frame_done;
            if (frame_done) begin
                pend_data_q <= data_q;
                pend_op_q   <= shift_q[6:4];
                pend_err_q  <= frame_err;
            end
        end
    end

    // A frame may load only into an empty register or one being drained this cycle.
    always_comb begin
        load = done_q && (!out_valid_q || out_ready);
    end

    // Output register and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            out_op_q    <= 3'd0;
            out_err_q   <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= done_q && !load;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pend_data_q;
                out_op_q    <= pend_op_q;
                out_err_q   <= pend_err_q;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_B     = out_data_q[63:32];
    assign out_A     = out_data_q[31:0];
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_mtm_alu_deserializer;

    localparam logic [2:0] E_DATA = 3'b100;
    localparam logic [2:0] E_CRC  = 3'b010;
    localparam logic [2:0] E_OP   = 3'b001;

    typedef struct packed {
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
        logic [2:0]  err;
    } res_t;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_B;
    logic [31:0] out_A;
    logic [2:0]  out_op;
    logic [2:0]  out_err;
    logic        overrun;

    res_t        obs_q[$];
    res_t        exp_q[$];
    int          rd;
    int          ovr_cnt;
    int          n_cmp;
    int          n_fail;
    int          m_cnt;
    logic [63:0] m_data;

    mtm_alu_deserializer #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_B     (out_B),
        .out_A     (out_A),
        .out_op    (out_op),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ovr_cnt = 0;

    // Record every accepted result and every overrun pulse.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            obs_q.push_back({out_B, out_A, out_op, out_err});
        if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    // CRC as the remainder of the 72-bit message polynomial divided by x^4+x+1.
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
        logic [71:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    task automatic send_byte(input logic t, input logic [7:0] p);
        logic [10:0] bits;
        bits = {1'b0, t, p, 1'b1};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = bits[i];
        end
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [7:0] ctl);
        logic [63:0] d;
        d = {b, a};
        for (int i = 0; i < 8; i++) send_byte(1'b0, d[63 - 8*i -: 8]);
        send_byte(1'b1, ctl);
    endtask

    // Frame-level model: byte count, CRC and opcode rules applied per received byte.
    task automatic model_byte(input logic t, input logic [7:0] p);
        res_t r;
        if (!t && m_cnt < 8) begin
            m_data = {m_data[55:0], p};
            m_cnt++;
            return;
        end
        r = '0;
        if (!t || m_cnt != 8) begin
            r.err = E_DATA;
        end else begin
            r.b  = m_data[63:32];
            r.a  = m_data[31:0];
            r.op = p[6:4];
            if (p[3:0] != crc_ref(r.b, r.a, r.op)) r.err = E_CRC;
            else if (!(r.op inside {3'b000, 3'b001, 3'b100, 3'b101})) r.err = E_OP;
        end
        exp_q.push_back(r);
        m_cnt = 0;
    endtask

    task automatic send_m(input logic t, input logic [7:0] p);
        model_byte(t, p);
        send_byte(t, p);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && (obs_q.size() - rd) < n; i++) @(negedge clk);
    endtask

    task automatic send_random_frame(input int max_gap);
        int          kind;
        int          ndata;
        logic [31:0] b, a;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic [63:0] d;
        kind  = int'($urandom_range(0, 9));
        b     = $urandom;
        a     = $urandom;
        op    = 3'($urandom_range(0, 7));
        crc   = crc_ref(b, a, op);
        if (kind == 0) crc = crc ^ 4'($urandom_range(1, 15));
        ndata = (kind == 1) ? int'($urandom_range(0, 7)) : 8;
        d     = {b, a};
        for (int i = 0; i < ndata; i++) begin
            send_m(1'b0, d[63 - 8*i -: 8]);
            send_idle(int'($urandom_range(0, max_gap)));
        end
        if (kind == 2) begin
            send_m(1'b0, 8'($urandom));
            send_idle(int'($urandom_range(0, max_gap)));
        end
        send_m(1'b1, {1'b0, op, crc});
        send_idle(int'($urandom_range(0, max_gap)));
    endtask

    task automatic run_random_frames(input int nframes, input int max_gap, input string tag);
        int n_obs;
        m_cnt = 0;
        exp_q.delete();
        rd = obs_q.size();
        for (int f = 0; f < nframes; f++) send_random_frame(max_gap);
        wait_obs(exp_q.size(), 200);
        send_idle(20);
        n_obs = obs_q.size() - rd;
        n_cmp++;
        if (n_obs != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d results, expected %0d", tag, n_obs, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && rd < obs_q.size(); i++) begin
            res_t o;
            res_t e;
            o = obs_q[rd];
            e = exp_q[i];
            rd++;
            n_cmp++;
            if (o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s[%0d] err: got %b expected %b", tag, i, o.err, e.err);
            end
            if (e.err != E_DATA) begin
                n_cmp++;
                if ({o.b, o.a, o.op} !== {e.b, e.a, e.op}) begin
                    n_fail++;
                    $display("FAIL %s[%0d] data: got B=%h A=%h op=%b expected B=%h A=%h op=%b",
                             tag, i, o.b, o.a, o.op, e.b, e.a, e.op);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        sin       = 1'b1;
        out_ready = 1'b1;
        rd        = 0;
        send_idle(3);
        n_cmp++;
        if ({out_valid, out_B, out_A, out_op, out_err, overrun} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got valid=%b B=%h A=%h op=%b err=%b ovr=%b expected all 0",
                     out_valid, out_B, out_A, out_op, out_err, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        send_idle(5);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_directed;
        logic [7:0] ctl [3];
        logic [2:0] eerr [3];
        logic [2:0] eop [3];
        ctl  = '{8'h0B, 8'h0C, 8'h2D};
        eerr = '{3'b000, 3'b010, 3'b001};
        eop  = '{3'b000, 3'b000, 3'b010};
        for (int v = 0; v < 3; v++) begin
            rd = obs_q.size();
            send_frame(32'd0, 32'd0, ctl[v]);
            wait_obs(1, 50);
            n_cmp++;
            if (obs_q.size() - rd < 1) begin
                n_fail++;
                $display("FAIL directed[%0d] timeout: got no result expected one", v);
            end else begin
                if ({obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err}
                    !== {64'd0, eop[v], eerr[v]}) begin
                    n_fail++;
                    $display("FAIL directed[%0d]: got B=%h A=%h op=%b err=%b expected 0/0/%b/%b",
                             v, obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err,
                             eop[v], eerr[v]);
                end
            end
            send_idle(3);
        end
    endtask

    task automatic test_latency;
        logic [31:0] b, a;
        b = $urandom;
        a = $urandom;
        send_frame(b, a, {1'b0, 3'b101, crc_ref(b, a, 3'b101)});
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency early: got valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: got valid=%b expected 1", out_valid);
        end
        n_cmp++;
        if ({out_B, out_A, out_op, out_err} !== {b, a, 3'b101, 3'b000}) begin
            n_fail++;
            $display("FAIL latency data: got B=%h A=%h op=%b err=%b expected %h/%h/101/000",
                     out_B, out_A, out_op, out_err, b, a);
        end
        send_idle(3);
    endtask

    task automatic test_bad_length;
        logic [31:0] b, a;
        b  = $urandom;
        a  = $urandom;
        rd = obs_q.size();
        for (int i = 0; i < 9; i++) send_byte(1'b0, 8'($urandom));
        send_frame(b, a, {1'b0, 3'b000, crc_ref(b, a, 3'b000)});
        wait_obs(2, 60);
        n_cmp++;
        if (obs_q.size() - rd < 2) begin
            n_fail++;
            $display("FAIL bad_length count: got %0d expected 2", obs_q.size() - rd);
        end else begin
            n_cmp++;
            if (obs_q[rd].err !== E_DATA) begin
                n_fail++;
                $display("FAIL bad_length err: got %b expected %b", obs_q[rd].err, E_DATA);
            end
            if ({obs_q[rd+1].b, obs_q[rd+1].a, obs_q[rd+1].op, obs_q[rd+1].err}
                !== {b, a, 3'b000, 3'b000}) begin
                n_fail++;
                $display("FAIL bad_length recover: got B=%h A=%h op=%b err=%b expected %h/%h/000/000",
                         obs_q[rd+1].b, obs_q[rd+1].a, obs_q[rd+1].op, obs_q[rd+1].err, b, a);
            end
        end
        send_idle(3);
    endtask

    task automatic test_random;
        run_random_frames(20, 3, "random");
    endtask

    task automatic test_back_to_back;
        run_random_frames(8, 0, "back_to_back");
    endtask

    task automatic test_overrun;
        logic [31:0] b1, a1, b2, a2;
        int          ovr0;
        b1 = $urandom;
        a1 = $urandom;
        b2 = $urandom;
        a2 = $urandom;
        @(negedge clk);
        out_ready = 1'b0;
        ovr0      = ovr_cnt;
        send_frame(b1, a1, {1'b0, 3'b100, crc_ref(b1, a1, 3'b100)});
        send_frame(b2, a2, {1'b0, 3'b101, crc_ref(b2, a2, 3'b101)});
        send_idle(5);
        n_cmp++;
        if ({out_valid, out_B, out_A, out_op, out_err} !== {1'b1, b1, a1, 3'b100, 3'b000}) begin
            n_fail++;
            $display("FAIL overrun hold: got v=%b B=%h A=%h op=%b err=%b expected 1/%h/%h/100/000",
                     out_valid, out_B, out_A, out_op, out_err, b1, a1);
        end
        n_cmp++;
        if (ovr_cnt - ovr0 != 1) begin
            n_fail++;
            $display("FAIL overrun pulses: got %0d expected 1", ovr_cnt - ovr0);
        end
        rd = obs_q.size();
        @(negedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun drain: got valid=%b expected 0", out_valid);
        end
        send_idle(30);
        n_cmp++;
        if (obs_q.size() - rd != 0) begin
            n_fail++;
            $display("FAIL overrun lost frame: got %0d late results expected 0", obs_q.size() - rd);
        end
    endtask

    task automatic test_mid_reset;
        rd = obs_q.size();
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'($urandom));
        @(negedge clk) sin = 1'b0;
        @(negedge clk) sin = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk) sin = 1'($urandom);
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_frame(32'h1, 32'h2, {1'b0, 3'b100, crc_ref(32'h1, 32'h2, 3'b100)});
        wait_obs(1, 50);
        send_idle(30);
        n_cmp++;
        if (obs_q.size() - rd != 1) begin
            n_fail++;
            $display("FAIL mid_reset count: got %0d expected 1", obs_q.size() - rd);
        end else begin
            n_cmp++;
            if ({obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err}
                !== {32'h1, 32'h2, 3'b100, 3'b000}) begin
                n_fail++;
                $display("FAIL mid_reset data: got B=%h A=%h op=%b err=%b expected 1/2/100/000",
                         obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err);
            end
        end
    endtask

`ifdef MTM_ALU_DESER_TIMEOUT_EN
    task automatic test_timeout;
        rd = obs_q.size();
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'($urandom));
        send_idle(40);
        n_cmp++;
        if (obs_q.size() - rd != 0) begin
            n_fail++;
            $display("FAIL timeout early: got %0d results expected 0", obs_q.size() - rd);
        end
        wait_obs(1, 60);
        n_cmp++;
        if (obs_q.size() - rd < 1) begin
            n_fail++;
            $display("FAIL timeout missing: got no result expected err %b", E_DATA);
        end else if (obs_q[rd].err !== E_DATA) begin
            n_fail++;
            $display("FAIL timeout err: got %b expected %b", obs_q[rd].err, E_DATA);
        end
        send_idle(5);
    endtask
`else
    task automatic test_no_timeout;
        logic [31:0] b, a;
        logic [63:0] d;
        b  = $urandom;
        a  = $urandom;
        d  = {b, a};
        rd = obs_q.size();
        for (int i = 0; i < 3; i++) send_byte(1'b0, d[63 - 8*i -: 8]);
        send_idle(150);
        n_cmp++;
        if (obs_q.size() - rd != 0) begin
            n_fail++;
            $display("FAIL no_timeout early: got %0d results expected 0", obs_q.size() - rd);
        end
        for (int i = 3; i < 8; i++) send_byte(1'b0, d[63 - 8*i -: 8]);
        send_byte(1'b1, {1'b0, 3'b001, crc_ref(b, a, 3'b001)});
        wait_obs(1, 50);
        n_cmp++;
        if (obs_q.size() - rd < 1) begin
            n_fail++;
            $display("FAIL no_timeout resume: got no result expected one");
        end else if ({obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err}
                     !== {b, a, 3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL no_timeout data: got B=%h A=%h op=%b err=%b expected %h/%h/001/000",
                     obs_q[rd].b, obs_q[rd].a, obs_q[rd].op, obs_q[rd].err, b, a);
        end
        send_idle(5);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_cnt  = 0;
        m_data = 64'd0;
        test_reset();
        test_directed();
        test_latency();
        test_bad_length();
        test_random();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
`ifdef MTM_ALU_DESER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
